// File: rtl/polyphase_pkg.sv
// Shared types for the polyphase controller: FSM state encoding and phase-index width.
// No logic, no latency.
// No flow control.
package polyphase_pkg;

  // Controller states: fetch one sample, broadcast it, then collect/emit each phase
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    BCAST   = 2'd1,
    COLLECT = 2'd2,
    OUT     = 2'd3
  } state_t;

  // Upper bound on the number of subfilter phases a controller may serve
  localparam int MAX_PHASES = 8;

  // Bits needed to hold a phase index 0..nr-1 (at least one bit)
  function automatic int phase_width(input int nr);
    return (nr <= 2) ? 1 : $clog2(nr);
  endfunction

  // Default phase-index width: wide enough for the largest supported phase count
  localparam int PW_DEFAULT = phase_width(MAX_PHASES);

endpackage

// File: rtl/polyphase_ctrl.sv
// Polyphase controller: fetches one sample, broadcasts it to all subfilters, then emits enabled phase outputs in order.
// Latency: 1 cycle per handshake step; all outputs registered.
// Backpressure: req/ack on both sides; the FSM stalls in place until the relevant ack/req arrives.
module polyphase_ctrl
  import polyphase_pkg::*;
#(
  parameter int NR_PHASES = 2,
  parameter int DWIDTH    = 16,
  parameter int PW        = PW_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        req_in,
  input  logic                        ack_in,
  input  logic [DWIDTH-1:0]           data_in,
  output logic                        req_out,
  input  logic                        ack_out,
  output logic [DWIDTH-1:0]           data_out,
  output logic [PW-1:0]               out_phase,
  input  logic [NR_PHASES-1:0]        phase_en,
  input  logic [NR_PHASES-1:0]        sf_req_in,
  output logic [NR_PHASES-1:0]        sf_ack_in,
  output logic [DWIDTH-1:0]           sf_data_in,
  input  logic [NR_PHASES-1:0]        sf_req_out,
  output logic [NR_PHASES-1:0]        sf_ack_out,
  input  logic [NR_PHASES*DWIDTH-1:0] sf_data_out,
  output logic                        busy
);

  localparam logic [PW-1:0] P_LAST = PW'(NR_PHASES - 1);

  state_t                state;
  logic [PW-1:0]         p;
  logic [NR_PHASES-1:0]  en_q;

  logic                  cur_req;
  logic                  cur_en;
  logic [DWIDTH-1:0]     cur_slice;
  logic [NR_PHASES-1:0]  cur_onehot;

  // Select request, enable bit, data slice and ack mask of the phase currently being collected
  always_comb begin
    cur_req    = 1'b0;
    cur_en     = 1'b0;
    cur_slice  = '0;
    cur_onehot = '0;
    for (int i = 0; i < NR_PHASES; i++) begin
      if (p == PW'(i)) begin
        cur_req       = sf_req_out[i];
        cur_en        = en_q[i];
        cur_slice     = sf_data_out[i*DWIDTH +: DWIDTH];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  // Main FSM: every output is a register; ack pulses default low so they last exactly one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH;
      p          <= '0;
      en_q       <= '0;
      req_in     <= 1'b0;
      req_out    <= 1'b0;
      sf_ack_in  <= '0;
      sf_ack_out <= '0;
      data_out   <= '0;
      sf_data_in <= '0;
      out_phase  <= '0;
      busy       <= 1'b0;
    end else begin
      sf_ack_in  <= '0;
      sf_ack_out <= '0;
      case (state)
        FETCH: begin
          req_in <= 1'b1;
          if (req_in && ack_in) begin
            // sf_data_in doubles as the sample holding register until the next fetch
            sf_data_in <= data_in;
            en_q       <= phase_en;
            req_in     <= 1'b0;
            busy       <= 1'b1;
            state      <= BCAST;
          end
        end

        BCAST: begin
          // All subfilters take the sample together, enabled or not, so their delay lines stay aligned
          if (&sf_req_in) begin
            sf_ack_in <= '1;
            p         <= '0;
            state     <= COLLECT;
          end
        end

        COLLECT: begin
          if (|sf_ack_out) begin
            // The drain pulse has just been issued; forward the sample or drop it
            if (cur_en) begin
              req_out <= 1'b1;
              state   <= OUT;
            end else if (p == P_LAST) begin
              p      <= '0;
              req_in <= 1'b1;
              busy   <= 1'b0;
              state  <= FETCH;
            end else begin
              p     <= p + 1'b1;
              state <= COLLECT;
            end
          end else if (cur_req) begin
            // Only the current phase is looked at; early requests from later phases wait their turn
            data_out   <= cur_slice;
            out_phase  <= p;
            sf_ack_out <= cur_onehot;
          end
        end

        OUT: begin
          if (req_out && ack_out) begin
            req_out <= 1'b0;
            if (p == P_LAST) begin
              p      <= '0;
              req_in <= 1'b1;
              busy   <= 1'b0;
              state  <= FETCH;
            end else begin
              p     <= p + 1'b1;
              state <= COLLECT;
            end
          end
        end

        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // The two subfilter ack groups are never active together
  a_ack_excl: assert property (@(posedge clk) disable iff (!rst)
    !((|sf_ack_in) && (|sf_ack_out)));

  // At most one subfilter is drained per cycle
  a_ack_out_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(sf_ack_out));

  // A stalled output keeps its valid, data and phase untouched
  a_out_hold: assert property (@(posedge clk) disable iff (!rst)
    (req_out && !ack_out) |=> (req_out && $stable(data_out) && $stable(out_phase)));

endmodule

// File: tb/tb_polyphase_ctrl.sv
// Self-checking bench for polyphase_ctrl: table vectors, randomized samples against a reference model,
// and hand-written reset sequences.
// Subfilters and upstream/downstream partners are modelled cycle by cycle at the falling edge.
module tb_polyphase_ctrl;

  localparam int NP = 2;
  localparam int DW = 16;
  localparam int PW = 3;
  localparam int LIMIT = 400;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 req_in;
  logic                 ack_in = 1'b0;
  logic [DW-1:0]        data_in = '0;
  logic                 req_out;
  logic                 ack_out = 1'b0;
  logic [DW-1:0]        data_out;
  logic [PW-1:0]        out_phase;
  logic [NP-1:0]        phase_en = '0;
  logic [NP-1:0]        sf_req_in = '0;
  logic [NP-1:0]        sf_ack_in;
  logic [DW-1:0]        sf_data_in;
  logic [NP-1:0]        sf_req_out = '0;
  logic [NP-1:0]        sf_ack_out;
  logic [NP*DW-1:0]     sf_data_out = '0;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  logic [PW+DW-1:0] got_q[$];
  logic [PW+DW-1:0] exp_q[$];

  typedef struct {
    logic [DW-1:0]    din;
    logic [NP-1:0]    en;
    logic [DW-1:0]    s0;
    logic [DW-1:0]    s1;
    int               id0, id1;
    int               od0, od1;
    int               stall;
    int               e_n;
    logic [PW+DW-1:0] e0;
    logic [PW+DW-1:0] e1;
  } vec_t;

  vec_t vecs[6];

  polyphase_ctrl #(.NR_PHASES(NP), .DWIDTH(DW), .PW(PW)) dut (
    .clk(clk), .rst(rst),
    .req_in(req_in), .ack_in(ack_in), .data_in(data_in),
    .req_out(req_out), .ack_out(ack_out), .data_out(data_out), .out_phase(out_phase),
    .phase_en(phase_en),
    .sf_req_in(sf_req_in), .sf_ack_in(sf_ack_in), .sf_data_in(sf_data_in),
    .sf_req_out(sf_req_out), .sf_ack_out(sf_ack_out), .sf_data_out(sf_data_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: every enabled phase appears once, in ascending phase order, carrying its slice verbatim
  task automatic build_expected(input logic [NP-1:0] en, input logic [DW-1:0] s0, input logic [DW-1:0] s1);
    logic [DW-1:0] slices[NP];
    slices[0] = s0;
    slices[1] = s1;
    exp_q.delete();
    for (int ph = 0; ph < NP; ph++)
      if (en[ph]) exp_q.push_back({PW'(ph), slices[ph]});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_in"},     req_in,     0);
    chk({tag, "_req_out"},    req_out,    0);
    chk({tag, "_sf_ack_in"},  sf_ack_in,  0);
    chk({tag, "_sf_ack_out"}, sf_ack_out, 0);
    chk({tag, "_data_out"},   data_out,   0);
    chk({tag, "_sf_data_in"}, sf_data_in, 0);
    chk({tag, "_out_phase"},  out_phase,  0);
    chk({tag, "_busy"},       busy,       0);
  endtask

  // One full sample: fetch, broadcast, drain both phases, emit enabled ones; outputs collected into got_q
  task automatic run_sample(input logic [DW-1:0] din, input logic [NP-1:0] en,
                            input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                            input int id0, input int id1, input int od0, input int od1,
                            input int stall, input bit noise);
    int t, n, bc_t, bc_cnt, ro_cnt;
    bit bc_done, bc_bad, overlap_bad, stable_bad, sdi_bad, order_bad;
    bit [NP-1:0] done_o;
    int ack_order[$];
    int in_d[NP];
    int out_d[NP];
    logic [PW+DW-1:0] held;

    in_d[0] = id0; in_d[1] = id1;
    out_d[0] = od0; out_d[1] = od1;
    got_q.delete();
    bc_t = 0; bc_cnt = 0; ro_cnt = 0; held = '0;
    bc_done = 0; bc_bad = 0; overlap_bad = 0; stable_bad = 0; sdi_bad = 0; order_bad = 0;
    done_o = '0;
    sf_data_out = {s1, s0};

    for (n = 0; n < 50 && req_in !== 1'b1; n++) @(negedge clk);
    chk("req_in_ready", req_in, 1);
    data_in  = din;
    phase_en = en;
    ack_in   = 1'b1;
    @(negedge clk);
    ack_in = 1'b0;
    chk("req_in_drop", req_in, 0);
    chk("busy_after_fetch", busy, 1);

    for (t = 0; t < LIMIT; t++) begin
      if (sf_data_in !== din) sdi_bad = 1;
      if (sf_ack_in != 0 && sf_ack_out != 0) overlap_bad = 1;
      if (sf_ack_in != 0) begin
        bc_cnt++;
        if (sf_ack_in !== 2'b11 || sf_req_in !== 2'b11) bc_bad = 1;
        bc_done = 1;
        bc_t = t;
      end
      if (sf_ack_out != 0) begin
        if (!$onehot(sf_ack_out)) order_bad = 1;
        for (int i = 0; i < NP; i++) begin
          if (sf_ack_out[i]) begin
            ack_order.push_back(i);
            if (i > 0 && !done_o[i-1]) order_bad = 1;
            done_o[i] = 1'b1;
          end
        end
      end
      if (req_out === 1'b1) begin
        if (ro_cnt > 0 && ({out_phase, data_out} !== held || sf_ack_out != 0)) stable_bad = 1;
        held = {out_phase, data_out};
        if (ro_cnt >= stall) begin
          ack_out = 1'b1;
          got_q.push_back(held);
          ro_cnt = 0;
        end else begin
          ack_out = 1'b0;
          ro_cnt++;
        end
      end else begin
        ro_cnt  = 0;
        ack_out = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (bc_done && req_in === 1'b1) break;
      for (int i = 0; i < NP; i++) begin
        sf_req_in[i]  = !bc_done && (t >= in_d[i]);
        sf_req_out[i] = bc_done && !done_o[i] && ((t - bc_t) >= out_d[i]);
      end
      if (noise) begin
        ack_in   = 1'($urandom_range(0, 1));
        phase_en = NP'($urandom);
      end
      @(negedge clk);
    end
    ack_in = 1'b0; ack_out = 1'b0; sf_req_in = '0; sf_req_out = '0;

    chk("sample_done_in_time", (t < LIMIT), 1);
    chk("bcast_pulse_count", bc_cnt, 1);
    chk("bcast_ok", bc_bad, 0);
    chk("ack_overlap", overlap_bad, 0);
    chk("out_hold_stable", stable_bad, 0);
    chk("sf_data_in_stable", sdi_bad, 0);
    chk("drain_order_ok", order_bad, 0);
    chk("drain_count", ack_order.size(), NP);
    chk("out_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("out_item", got_q[i], exp_q[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{16'h0100, 2'b11, 16'h0011, 16'h0022, 0, 0, 0, 0, 0,  2, {3'd0, 16'h0011}, {3'd1, 16'h0022}};
    vecs[1] = '{16'h0200, 2'b10, 16'h0011, 16'h0022, 0, 0, 0, 0, 0,  1, {3'd1, 16'h0022}, '0};
    vecs[2] = '{16'h0300, 2'b11, 16'h0033, 16'h0044, 0, 0, 5, 0, 0,  2, {3'd0, 16'h0033}, {3'd1, 16'h0044}};
    vecs[3] = '{16'h0400, 2'b01, 16'h8001, 16'h0055, 0, 0, 0, 0, 20, 1, {3'd0, 16'h8001}, '0};
    vecs[4] = '{16'h0500, 2'b11, 16'h0066, 16'hFFFF, 0, 10, 1, 2, 2, 2, {3'd0, 16'h0066}, {3'd1, 16'hFFFF}};
    vecs[5] = '{16'h0600, 2'b00, 16'h0077, 16'h0088, 0, 0, 0, 0, 0,  0, '0, '0};

    // Reset state and first-edge behaviour after release
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    #1;
    chk("req_in_before_edge", req_in, 0);
    @(negedge clk);
    chk("req_in_after_release", req_in, 1);
    chk("busy_in_fetch", busy, 0);

    // Table vectors
    foreach (vecs[k]) begin
      exp_q.delete();
      if (vecs[k].e_n > 0) exp_q.push_back(vecs[k].e0);
      if (vecs[k].e_n > 1) exp_q.push_back(vecs[k].e1);
      run_sample(vecs[k].din, vecs[k].en, vecs[k].s0, vecs[k].s1,
                 vecs[k].id0, vecs[k].id1, vecs[k].od0, vecs[k].od1, vecs[k].stall, 1'b0);
    end

    // Randomized samples against the reference model, with ack/phase_en noise outside the handshakes
    for (int r = 0; r < 24; r++) begin
      logic [DW-1:0] din, s0, s1;
      logic [NP-1:0] en;
      din = DW'($urandom); s0 = DW'($urandom); s1 = DW'($urandom); en = NP'($urandom);
      build_expected(en, s0, s1);
      run_sample(din, en, s0, s1, $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), 1'b1);
    end

    // Reset asserted while waiting for phase 1 in COLLECT
    for (n = 0; n < 50 && req_in !== 1'b1; n++) @(negedge clk);
    sf_data_out = {16'h0bbb, 16'h0aaa};
    data_in = 16'h5a5a; phase_en = 2'b00; ack_in = 1'b1;
    @(negedge clk);
    ack_in = 1'b0; sf_req_in = 2'b11;
    for (n = 0; n < 50 && sf_ack_in == 0; n++) @(negedge clk);
    sf_req_in = 2'b00; sf_req_out = 2'b01;
    for (n = 0; n < 50 && sf_ack_out == 0; n++) @(negedge clk);
    sf_req_out = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("mid_data_out", data_out, 16'h0aaa);
    chk("mid_busy", busy, 1);
    chk("mid_no_req_out", req_out, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("req_in_before_edge2", req_in, 0);
    @(negedge clk);
    chk("req_in_after_release2", req_in, 1);

    // Clean operation after the abort
    build_expected(2'b11, 16'h1234, 16'h4321);
    run_sample(16'h0700, 2'b11, 16'h1234, 16'h4321, 1, 0, 0, 1, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
